// File: rtl/stage_d_writeback_buffered_pkg.sv
// Shared opcode bit positions and sizing for the writeback stage.
// Opcode bits mirror the one-hot layout used across the pipeline.
package stage_d_writeback_buffered_pkg;

  localparam int A_WIDTH    = 12;
  localparam int D_WIDTH    = 8;
  localparam int DEPTH      = 4;
  localparam int DEPTH_LOG2 = 2;

  localparam int OP_INC     = 0;
  localparam int OP_DEC     = 1;
  localparam int OP_PINC    = 2;
  localparam int OP_PDEC    = 3;
  localparam int OP_IN      = 4;
  localparam int OP_OUT     = 5;
  localparam int OP_JZ      = 6;
  localparam int OP_JNZ     = 7;
  localparam int OPCODE_MSB = 7;

  typedef logic [OPCODE_MSB:0] opcode_t;

  typedef struct packed {
    opcode_t operation;
    logic    drdy;
  } retire_t;

  function automatic logic is_dram_write(input opcode_t op);
    return op[OP_INC] | op[OP_DEC] | op[OP_IN];
  endfunction

endpackage

// File: rtl/stage_d_writeback_buffered_if.sv
// Stage C / data RAM / external port signals of the writeback stage.
// slave is the stage side, master the side that drives the stage.
interface stage_d_writeback_buffered_if #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8,
  parameter int OPW     = 8,
  parameter int CNTW    = 3
);
  logic [A_WIDTH-1:0] dp;
  logic [D_WIDTH-1:0] a_in;
  logic [OPW-1:0]     operation_in;
  logic               drdy_in;
  logic               ack_in;
  logic               dce;
  logic [A_WIDTH-1:0] da;
  logic [D_WIDTH-1:0] dq;
  logic [7:0]         cq;
  logic               cwre;
  logic               cbsy;
  logic               ack;
  logic [OPW-1:0]     operation;
  logic               drdy;
  logic               fifo_empty;
  logic [CNTW-1:0]    fifo_count;

  modport slave (
    input  dp, a_in, operation_in, drdy_in, ack_in, cbsy,
    output dce, da, dq, cq, cwre, ack, operation, drdy, fifo_empty, fifo_count
  );

  modport master (
    output dp, a_in, operation_in, drdy_in, ack_in, cbsy,
    input  dce, da, dq, cq, cwre, ack, operation, drdy, fifo_empty, fifo_count
  );
endinterface

// File: rtl/stage_d_writeback_buffered_fifo.sv
// Show-ahead synchronous FIFO: dout_o is the head entry whenever empty_o is low.
// Flags decode the registered count, so they never depend on this cycle's push/pop.
module sync_fifo_fwft #(
  parameter int W          = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [W-1:0]          din_i,
  input  logic                  pop_i,
  output logic [W-1:0]          dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);

  logic [W-1:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Push is judged on the pre-pop full flag, so a full FIFO refuses even while popping.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/stage_d_writeback_buffered.sv
// Pipeline stage D: data RAM writeback plus a buffered OUT port.
// OUT only stalls stage C when the byte FIFO is already full.
module stage_d_writeback_buffered
  import stage_d_writeback_buffered_pkg::*;
#(
  parameter int A_WIDTH_P    = A_WIDTH,
  parameter int D_WIDTH_P    = D_WIDTH,
  parameter int DEPTH_P      = DEPTH,
  parameter int DEPTH_LOG2_P = DEPTH_LOG2
) (
  input  logic                          clk,
  input  logic                          reset,
  stage_d_writeback_buffered_if.slave   bus
);

  logic       is_out, stall, fifo_full, fifo_empty_w, push, pop;
  logic [7:0] fifo_dout;
  logic [DEPTH_LOG2_P:0] fifo_count_w;
  retire_t    retire_q, retire_d;

  assign bus.dce = is_dram_write(bus.operation_in);
  assign bus.da  = bus.dp;
  assign bus.dq  = bus.a_in;

  assign is_out  = bus.operation_in[OP_OUT];
  assign stall   = is_out & fifo_full;
  assign bus.ack = bus.ack_in & ~stall;
  assign push    = bus.ack_in & is_out & ~fifo_full;

  // cbsy only gates the drain side; it never reaches ack.
  assign pop      = ~fifo_empty_w & ~bus.cbsy;
  assign bus.cwre = pop;
  assign bus.cq   = fifo_dout;

  sync_fifo_fwft #(
    .W          (8),
    .DEPTH      (DEPTH_P),
    .DEPTH_LOG2 (DEPTH_LOG2_P)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (bus.a_in[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty_w),
    .count_o (fifo_count_w)
  );

  // A stalled OUT retires as a bubble; stage C re-presents it next cycle.
  always_comb begin
    retire_d = retire_q;
    if (bus.ack_in) begin
      if (stall) begin
        retire_d = '0;
      end else begin
        retire_d.operation = bus.operation_in;
        retire_d.drdy      = bus.drdy_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign bus.operation  = retire_q.operation;
  assign bus.drdy       = retire_q.drdy;
  assign bus.fifo_empty = fifo_empty_w;
  assign bus.fifo_count = fifo_count_w;

endmodule

// File: tb/tb_stage_d_writeback_buffered.sv
// Directed bench for the writeback stage: DRAM strobe, OUT buffering, stall/bubble,
// drain across pointer wrap against a byte queue, and reset during a drain.
module tb_stage_d_writeback_buffered;
  import stage_d_writeback_buffered_pkg::*;

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] OINC = 8'h01 << OP_INC;
  localparam logic [7:0] ODEC = 8'h01 << OP_DEC;
  localparam logic [7:0] OIN  = 8'h01 << OP_IN;
  localparam logic [7:0] OOUT = 8'h01 << OP_OUT;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  stage_d_writeback_buffered_if #(
    .A_WIDTH (12), .D_WIDTH (8), .OPW (8), .CNTW (3)
  ) bus ();

  stage_d_writeback_buffered dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic ackin);
    bus.operation_in = op;
    bus.a_in         = a;
    bus.ack_in       = ackin;
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int         idx, cyc;
    logic       bsy, full_pre, exp_ack, exp_cwre, out_now;

    reset = 1'b1;
    bus.dp = '0; bus.a_in = '0; bus.operation_in = '0;
    bus.drdy_in = 1'b0; bus.ack_in = 1'b0; bus.cbsy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_operation", bus.operation, 0);
    check("rst_drdy", bus.drdy, 0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_cwre", bus.cwre, 0);

    // INC writes data RAM and retires next cycle
    bus.dp = 12'h123; bus.drdy_in = 1'b1;
    drive(OINC, 8'h05, 1'b1);
    check("inc_dce", bus.dce, 1);
    check("inc_da", bus.da, 12'h123);
    check("inc_dq", bus.dq, 8'h05);
    check("inc_ack", bus.ack, 1);
    tick();
    check("inc_operation", bus.operation, OINC);
    check("inc_drdy", bus.drdy, 1);
    check("inc_cwre", bus.cwre, 0);
    drive(ODEC, 8'h04, 1'b1);
    check("dec_dce", bus.dce, 1);
    drive(OIN, 8'h07, 1'b1);
    check("in_dce", bus.dce, 1);

    // single OUT with idle port
    bus.drdy_in = 1'b0;
    drive(OOUT, 8'h41, 1'b1);
    check("out_dce", bus.dce, 0);
    check("out_ack", bus.ack, 1);
    check("out_cwre_same", bus.cwre, 0);
    tick();
    check("out_operation", bus.operation, OOUT);
    check("out_drdy", bus.drdy, 0);
    check("out_count", bus.fifo_count, 1);
    check("out_cwre", bus.cwre, 1);
    check("out_cq", bus.cq, 8'h41);
    drive(NOP, 8'h00, 1'b1);
    tick();
    check("out_empty_again", bus.fifo_empty, 1);
    check("out_cwre_off", bus.cwre, 0);

    // busy port: four OUTs fill the FIFO, the fifth stalls
    bus.cbsy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(OOUT, 8'h30 + 8'(i), 1'b1);
      check("fill_ack", bus.ack, 1);
      tick();
      check("fill_count", bus.fifo_count, i + 1);
      check("fill_cwre", bus.cwre, 0);
    end
    drive(OOUT, 8'h34, 1'b1);
    check("full_ack", bus.ack, 0);
    tick();
    check("full_bubble", bus.operation, 0);
    check("full_count", bus.fifo_count, 4);

    // port frees while full: pop happens, push refused this cycle
    bus.cbsy = 1'b0;
    #1;
    check("fullpop_ack", bus.ack, 0);
    check("fullpop_cwre", bus.cwre, 1);
    check("fullpop_cq", bus.cq, 8'h30);
    tick();
    check("fullpop_count", bus.fifo_count, 3);
    check("fullpop_bubble", bus.operation, 0);
    check("retry_ack", bus.ack, 1);
    check("retry_cq", bus.cq, 8'h31);
    tick();
    check("retry_count", bus.fifo_count, 3);
    check("retry_operation", bus.operation, OOUT);
    drive(NOP, 8'h00, 1'b1);
    check("drain_cq32", bus.cq, 8'h32);
    tick();
    check("drain_cq33", bus.cq, 8'h33);
    tick();
    check("drain_cq34", bus.cq, 8'h34);
    check("drain_cwre34", bus.cwre, 1);
    tick();
    check("drain_empty", bus.fifo_empty, 1);
    check("drain_cwre_off", bus.cwre, 0);

    // ten OUTs with random port busy, compared to a byte queue
    idx = 0; cyc = 0;
    while ((idx < 10 || q.size() != 0) && cyc < 300) begin
      bsy     = 1'($urandom_range(0, 1));
      out_now = (idx < 10);
      bus.cbsy = bsy;
      drive(out_now ? OOUT : NOP, 8'h50 + 8'(idx), 1'b1);
      full_pre = (q.size() == 4);
      exp_ack  = !(out_now && full_pre);
      exp_cwre = (q.size() != 0) && !bsy;
      check("rnd_ack", bus.ack, exp_ack);
      check("rnd_cwre", bus.cwre, exp_cwre);
      if (exp_cwre) begin
        check("rnd_cq", bus.cq, q[0]);
        void'(q.pop_front());
      end
      if (out_now && !full_pre) begin
        q.push_back(8'h50 + 8'(idx));
        idx++;
      end
      tick();
      check("rnd_count", bus.fifo_count, q.size());
      cyc++;
    end
    check("rnd_sent", idx, 10);
    check("rnd_left", q.size(), 0);

    // reset in the middle of a drain discards pending bytes
    bus.cbsy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(OOUT, 8'h60 + 8'(i), 1'b1);
      tick();
    end
    check("pre_rst_count", bus.fifo_count, 3);
    reset = 1'b1;
    bus.cbsy = 1'b0;
    drive(NOP, 8'h00, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_count", bus.fifo_count, 0);
    check("mid_rst_empty", bus.fifo_empty, 1);
    check("mid_rst_cwre", bus.cwre, 0);
    check("mid_rst_operation", bus.operation, 0);
    drive(OOUT, 8'h70, 1'b1);
    tick();
    check("post_rst_cq", bus.cq, 8'h70);
    check("post_rst_cwre", bus.cwre, 1);
    check("post_rst_count", bus.fifo_count, 1);
    drive(NOP, 8'h00, 1'b1);
    tick();
    check("post_rst_empty", bus.fifo_empty, 1);
    check("post_rst_cwre_off", bus.cwre, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
